// File: rtl/decode_seq.sv
// TB4004 eight-phase sequencer/decoder: captures OPR/OPA (and a second-cycle imm8), issues one commit strobe per instruction.
// Optional trap on OPR F sub-op E/F when DECODE_SEQ_ILLEGAL_TRAP_EN is defined; otherwise those commit as NOP.
module decode_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] romNibble,
  input  logic       stall,
  output logic [2:0] phase,
  output logic       sync,
  output logic [3:0] aluOp,
  output logic [3:0] aluSubOp,
  output logic [3:0] opa,
  output logic       secondWord,
  output logic [7:0] imm8,
  output logic       execValid,
  output logic       accWe,
  output logic       carryWe,
  output logic       regWe,
  output logic       illegalOp
);

  typedef enum logic [2:0] {
    A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
    M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [3:0]  opr_q, opr_d;
  logic [3:0]  opa_q, opa_d;
  logic [7:0]  imm_q, imm_d;
  logic        sec_q, sec_d;

  logic        two_cycle;
  logic        commit;
  logic        acc_dec, carry_dec, reg_dec;
  logic        illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= A1;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      imm_q   <= 8'h00;
      sec_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      imm_q   <= imm_d;
      sec_q   <= sec_d;
    end
  end

  // JCN/JUN/JMS/ISZ always take two cycles; FIM/FIN only with an even OPA.
  always_comb begin
    two_cycle = 1'b0;
    case (opr_q)
      4'h1, 4'h4, 4'h5, 4'h7: two_cycle = 1'b1;
      4'h2, 4'h3:             two_cycle = ~opa_q[0];
      default:                two_cycle = 1'b0;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    imm_d   = imm_q;
    sec_d   = sec_q;
    if (!stall) begin
      phase_d = phase_e'(phase_q + 3'd1);
      case (phase_q)
        M1: begin
          if (sec_q) imm_d[7:4] = romNibble;
          else       opr_d      = romNibble;
        end
        M2: begin
          if (sec_q) imm_d[3:0] = romNibble;
          else       opa_d      = romNibble;
        end
        X3:      sec_d = ~sec_q & two_cycle;
        default: ;
      endcase
    end
  end

  assign commit = (phase_q == X3) && !stall && (sec_q || !two_cycle);

  always_comb begin
    acc_dec   = 1'b0;
    carry_dec = 1'b0;
    reg_dec   = 1'b0;
    case (opr_q)
      4'h2, 4'h3: reg_dec = sec_q & ~opa_q[0];
      4'h6, 4'h7: reg_dec = 1'b1;
      4'h8, 4'h9: begin
        acc_dec   = 1'b1;
        carry_dec = 1'b1;
      end
      4'hA, 4'hC, 4'hD: acc_dec = 1'b1;
      4'hB: begin
        acc_dec = 1'b1;
        reg_dec = 1'b1;
      end
      4'hE: begin
        acc_dec   = opa_q[3];
        carry_dec = (opa_q == 4'h8) || (opa_q == 4'hB);
      end
      4'hF: begin
        acc_dec   = opa_q inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
                                  4'h8, 4'h9, 4'hB, 4'hC};
        carry_dec = opa_q inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6,
                                  4'h7, 4'h8, 4'h9, 4'hA, 4'hB};
      end
      default: ;
    endcase
  end

`ifdef DECODE_SEQ_ILLEGAL_TRAP_EN
  assign illegal   = (opr_q == 4'hF) && (opa_q[3:1] == 3'b111);
  assign illegalOp = commit & illegal;
`else
  assign illegal   = 1'b0;
  assign illegalOp = 1'b0;
`endif

  assign accWe      = commit & acc_dec   & ~illegal;
  assign carryWe    = commit & carry_dec & ~illegal;
  assign regWe      = commit & reg_dec   & ~illegal;
  assign execValid  = commit;
  assign phase      = phase_q;
  assign sync       = (phase_q == A1);
  assign aluOp      = opr_q;
  assign aluSubOp   = opa_q;
  assign opa        = opa_q;
  assign secondWord = sec_q;
  assign imm8       = imm_q;

endmodule

// File: tb/tb_decode_seq.sv
// Bench for decode_seq: directed opcode table, stall and mid-instruction reset sequences, then random instructions vs a rule model.
module tb_decode_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] romNibble;
  logic       stall;
  logic [2:0] phase;
  logic       sync;
  logic [3:0] aluOp;
  logic [3:0] aluSubOp;
  logic [3:0] opa;
  logic       secondWord;
  logic [7:0] imm8;
  logic       execValid;
  logic       accWe;
  logic       carryWe;
  logic       regWe;
  logic       illegalOp;

  int errors = 0;
  int checks = 0;

`ifdef DECODE_SEQ_ILLEGAL_TRAP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  decode_seq dut (
    .clk(clk), .rst_n(rst_n), .romNibble(romNibble), .stall(stall),
    .phase(phase), .sync(sync), .aluOp(aluOp), .aluSubOp(aluSubOp), .opa(opa),
    .secondWord(secondWord), .imm8(imm8), .execValid(execValid),
    .accWe(accWe), .carryWe(carryWe), .regWe(regWe), .illegalOp(illegalOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0] opr, opa, hi, lo;
    logic       two, acc, car, rg, ill;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] code, input logic [4:0] e);
    vec_t v;
    v.opr = code[15:12]; v.opa = code[11:8]; v.hi = code[7:4]; v.lo = code[3:0];
    v.two = e[4]; v.acc = e[3]; v.car = e[2]; v.rg = e[1]; v.ill = e[0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_phase"}, 8'(phase), 8'd0);
    chk({tag, "_sync"}, 8'(sync), 8'd1);
    chk({tag, "_aluOp"}, 8'(aluOp), 8'd0);
    chk({tag, "_aluSubOp"}, 8'(aluSubOp), 8'd0);
    chk({tag, "_opa"}, 8'(opa), 8'd0);
    chk({tag, "_imm8"}, imm8, 8'd0);
    chk({tag, "_secondWord"}, 8'(secondWord), 8'd0);
    chk({tag, "_strobes"}, 8'({execValid, accWe, carryWe, regWe, illegalOp}), 8'd0);
  endtask

  // Reference rules, written directly from the opcode definitions.
  function automatic logic m_two(input logic [3:0] r, input logic [3:0] a);
    return (r inside {4'h1, 4'h4, 4'h5, 4'h7}) || ((r inside {4'h2, 4'h3}) && !a[0]);
  endfunction
  function automatic logic m_ill(input logic [3:0] r, input logic [3:0] a);
    return ILL_EN && (r == 4'hF) && (a inside {4'hE, 4'hF});
  endfunction
  function automatic logic m_acc(input logic [3:0] r, input logic [3:0] a);
    return !m_ill(r, a) && ((r inside {[4'h8:4'hD]}) ||
           (r == 4'hF && (a inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB, 4'hC})) ||
           (r == 4'hE && a >= 4'h8));
  endfunction
  function automatic logic m_car(input logic [3:0] r, input logic [3:0] a);
    return !m_ill(r, a) && ((r inside {4'h8, 4'h9}) ||
           (r == 4'hF && (a inside {[4'h0:4'h3], [4'h5:4'hB]})) ||
           (r == 4'hE && (a inside {4'h8, 4'hB})));
  endfunction
  function automatic logic m_reg(input logic [3:0] r, input logic [3:0] a);
    return (r inside {4'h6, 4'h7, 4'hB}) || ((r inside {4'h2, 4'h3}) && !a[0]);
  endfunction

  // Runs one instruction phase by phase; entered and left just after a rising edge.
  // smode: 0 no stall, 1 random stall, 2 three M2 stalls plus two X3 stalls.
  task automatic do_instr(input vec_t v, input int smode, input int abort_at, input string nm);
    int total;
    int s = 0;
    int clk_n = 0;
    int nexec = 0;
    int exec_clk = 0;
    int nst = 0;
    int m2_st = 0;
    int x3_st = 0;
    logic st;
    logic [2:0] ph;
    logic cyc;
    logic e_exec;
    total = v.two ? 16 : 8;
    while (s < total) begin
      ph  = 3'(s % 8);
      cyc = (s >= 8);
      case (smode)
        0:       st = 1'b0;
        1:       st = ($urandom_range(0, 4) == 0);
        default: st = (ph == 3'd4 && m2_st < 3) || (ph == 3'd7 && x3_st < 2);
      endcase
      if (st) nst++;
      if (st && ph == 3'd4) m2_st++;
      if (st && ph == 3'd7) x3_st++;
      stall = st;
      if (!st && ph == 3'd3)      romNibble = cyc ? v.hi : v.opr;
      else if (!st && ph == 3'd4) romNibble = cyc ? v.lo : v.opa;
      else                        romNibble = 4'($urandom);
      clk_n++;
      @(negedge clk);
      e_exec = (ph == 3'd7) && !st && (cyc == v.two);
      chk({nm, "_phase"}, 8'(phase), 8'(ph));
      chk({nm, "_sync"}, 8'(sync), 8'(ph == 3'd0));
      chk({nm, "_secondWord"}, 8'(secondWord), 8'(cyc));
      chk({nm, "_execValid"}, 8'(execValid), 8'(e_exec));
      chk({nm, "_accWe"}, 8'(accWe), 8'(e_exec & v.acc));
      chk({nm, "_carryWe"}, 8'(carryWe), 8'(e_exec & v.car));
      chk({nm, "_regWe"}, 8'(regWe), 8'(e_exec & v.rg));
      chk({nm, "_illegalOp"}, 8'(illegalOp), 8'(e_exec & v.ill));
      if (s >= 5) begin
        chk({nm, "_aluOp"}, 8'(aluOp), 8'(v.opr));
        chk({nm, "_aluSubOp"}, 8'(aluSubOp), 8'(v.opa));
        chk({nm, "_opa"}, 8'(opa), 8'(v.opa));
      end
      if (s >= 13) chk({nm, "_imm8"}, imm8, {v.hi, v.lo});
      if (execValid) begin
        nexec++;
        exec_clk = clk_n;
      end
      if (s == abort_at) begin
        #2 rst_n = 1'b0;
        #1 chk_reset_vals({nm, "_async"});
        chk({nm, "_abort_exec_count"}, 8'(nexec), 8'd0);
        @(posedge clk);
        #1 chk_reset_vals({nm, "_held"});
        rst_n = 1'b1;
        stall = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
      if (!st) s++;
    end
    chk({nm, "_exec_count"}, 8'(nexec), 8'd1);
    chk({nm, "_commit_clock"}, 8'(exec_clk), 8'(total + nst));
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // {opr,opa,hi,lo}, {two,acc,car,reg,ill}
    tbl.push_back(mk(16'hD500, 5'b01000));   // LDM 5
    tbl.push_back(mk(16'h4A5C, 5'b10000));   // JUN
    tbl.push_back(mk(16'h2237, 5'b10010));   // FIM
    tbl.push_back(mk(16'h2300, 5'b00000));   // SRC
    tbl.push_back(mk(16'h8300, 5'b01100));   // ADD
    tbl.push_back(mk(16'hFE00, {4'b0000, ILL_EN}));
    tbl.push_back(mk(16'hFF00, {4'b0000, ILL_EN}));
    tbl.push_back(mk(16'h73A1, 5'b10010));   // ISZ
    tbl.push_back(mk(16'hE800, 5'b01100));
    tbl.push_back(mk(16'hEB00, 5'b01100));
    tbl.push_back(mk(16'hE900, 5'b01000));
    tbl.push_back(mk(16'hE400, 5'b00000));
    tbl.push_back(mk(16'hF000, 5'b01100));
    tbl.push_back(mk(16'hF100, 5'b00100));
    tbl.push_back(mk(16'hF300, 5'b00100));
    tbl.push_back(mk(16'hF400, 5'b01000));
    tbl.push_back(mk(16'hFA00, 5'b00100));
    tbl.push_back(mk(16'hFC00, 5'b01000));
    tbl.push_back(mk(16'hFD00, 5'b00000));
    tbl.push_back(mk(16'h3096, 5'b10010));   // FIN
    tbl.push_back(mk(16'h3100, 5'b00000));   // JIN
    tbl.push_back(mk(16'h6100, 5'b00010));   // INC
    tbl.push_back(mk(16'hB300, 5'b01010));   // XCH
    tbl.push_back(mk(16'h15E7, 5'b10000));   // JCN

    stall = 1'b0;
    romNibble = 4'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("reset");
    @(posedge clk);
    #1 chk_reset_vals("reset_clk");
    rst_n = 1'b1;

    foreach (tbl[i]) do_instr(tbl[i], 0, -1, $sformatf("tbl%0d", i));

    do_instr(mk(16'h8300, 5'b01100), 2, -1, "stall_add");
    do_instr(mk(16'h5234, 5'b10000), 0, 14, "rst_jms");
    do_instr(mk(16'hD500, 5'b01000), 0, -1, "after_rst");

    for (int k = 0; k < 60; k++) begin
      rv.opr = 4'($urandom);
      rv.opa = 4'($urandom);
      rv.hi  = 4'($urandom);
      rv.lo  = 4'($urandom);
      rv.two = m_two(rv.opr, rv.opa);
      rv.ill = m_ill(rv.opr, rv.opa);
      rv.acc = m_acc(rv.opr, rv.opa);
      rv.car = m_car(rv.opr, rv.opa);
      rv.rg  = m_reg(rv.opr, rv.opa);
      do_instr(rv, 1, -1, $sformatf("rnd%0d_%h%h", k, rv.opr, rv.opa));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
